fifo_addr_ctrl: RTL and testbench
=================================

# fifo_addr_ctrl

Shared address generator for the delay FIFOs of the NTT/INTT butterfly pipelines. It serves `NTT_CNT` forward-NTT clients and `INTT_CNT` inverse-NTT clients. Each pipeline stage gets one wrap-around write/read pointer, and the multiplier-stage FIFO gets one more. Client stage enables are merged per stage: NTT clients in reversed stage order, INTT clients in natural order. Per-stage collisions are flagged, and the block supports a synchronous flush between polynomials.

## Interface
Parameters:
- `NTT_STAGE_CNT`, default 8: number of butterfly stages (S); must be ≥ 3.
- `MUL_STAGE_CNT`, default 4: multiplier pipeline depth; the fifom pointer wraps modulo `MUL_STAGE_CNT-1`.
- `NTT_CNT`, default 1: number of forward-NTT clients; ≥ 1.
- `INTT_CNT`, default 1: number of inverse-NTT clients; ≥ 1.
- Derived, not overridable:
  - `AW` = clog2(max(2^(S-2), `MUL_STAGE_CNT`)).
  - `MB` = max(1, clog2(`MUL_STAGE_CNT-1`)).
  - Stage depth D_k = 2^min(k, S-2).

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ntt_en` input NTT_CNT*S: enable of NTT client c, stage j, at bit c*S+j.
- `intt_en` input INTT_CNT*S: enable of INTT client c, stage j, at bit c*S+j.
- `fifom_en` input 1: advance the multiplier FIFO pointer.
- `flush` input 1: clear all pointers.
- `clr_err` input 1: clear the sticky conflict flags.
- `fifom_addr` output MB: multiplier FIFO pointer.
- `fifo2_addr` output S*AW: controller stage k pointer, at bits [k*AW +: AW].
- `ntt_addr` output S*AW: pointer for NTT stage j = controller stage S-1-j.
- `intt_addr` output S*AW: pointer for INTT stage j = controller stage j.
- `conflict` output S: sticky per-controller-stage collision flag.
- `busy` output 1: high while any pointer is nonzero.

## Operation
- Merged enable: en_k = OR over c of ntt_en[c*S+S-1-k], OR over c of intt_en[c*S+k].
- Requester count: n_k = number of bits contributing to en_k.
- Stage pointer p_k (AW bits, upper bits unused when D_k < 2^AW):
  - If en_k is high: p_k ← (p_k == D_k-1) ? 0 : p_k+1.
  - Stage 0 has D_0 = 1, so p_0 stays 0.
  - Exactly one increment per cycle, regardless of n_k.
- Fifom pointer: if `fifom_en` is high, `fifom_addr` ← (`fifom_addr` == `MUL_STAGE_CNT`-2) ? 0 : `fifom_addr`+1.
- Conflict flag:
  - conflict[k] sets when n_k ≥ 2.
  - It stays set until `clr_err`, `rst` or `flush`.
  - If `clr_err` and a new collision occur in the same cycle, the set wins.
- Priority per cycle: `rst` > `flush` > enables.
  - `flush` zeroes every pointer and conflict flag; enables in that cycle are ignored.
- `ntt_addr` and `intt_addr` are pure rewiring of the pointer registers; no extra logic.
- `busy` = OR of all p_k and `fifom_addr` being nonzero, computed combinationally from the registers.
- No internal state machine beyond the counters. Clients own the read/write sequencing: the same pointer serves as write address and read address of a D_k-deep circular delay line.

## Timing
- Reset values:
  - all p_k = 0, `fifom_addr` = 0, `conflict` = 0.
  - therefore `busy` = 0 and all address outputs = 0.
- Latency: an enable sampled at edge t shows on the address outputs after edge t, i.e. one cycle. Outputs are registered except for `busy` and the rewiring.
- Back-to-back enables advance one step per cycle. Wrap-around happens in the cycle after pointer value D_k-1, with no bubble.
- `flush` asserted mid-operation: all pointers read 0 in the next cycle. An enable in the cycle after `flush` advances from 0.
- Enables held while `rst` is high have no effect.

## Test plan
- Reset then idle (S=8, MUL=4): all address outputs, `conflict` and `busy` stay 0 for 10 cycles.
- Hold intt_en[3] for 9 cycles (D_3 = 8):
  - `intt_addr` stage 3 reads 1,2,…,7,0,1.
  - `ntt_addr` stage 4 mirrors it.
  - other stages stay 0.
  - `busy` drops exactly on the cycle the pointer reads 0.
- Hold ntt_en[0] (maps to controller stage 7, D_7 = 64) for 64 cycles: the pointer wraps back to 0 on cycle 64; `conflict[7]` stays 0.
- Pulse ntt_en[4] and intt_en[3] in the same cycle:
  - p_3 advances by 1 only.
  - `conflict[3]` = 1 and holds.
  - `clr_err` clears it the next cycle.
  - `clr_err` together with a repeat collision leaves it at 1.
- `fifom_en` held for 4 cycles (MUL=4): `fifom_addr` reads 1,2,0,1.
- Flush mid-run:
  - raise p_5 to 13 and `fifom_addr` to 2.
  - assert `flush` together with intt_en[5].
  - all pointers, `conflict` and `busy` read 0 next cycle.
  - a following enable yields p_5 = 1.

Source files
------------

// File: rtl/fifo_addr_ctrl_if.sv
// fifo_addr_ctrl_if: client enables and pointer outputs of the shared delay-FIFO address generator.
interface fifo_addr_ctrl_if #(
  parameter int NTT_STAGE_CNT = 8,
  parameter int MUL_STAGE_CNT = 4,
  parameter int NTT_CNT       = 1,
  parameter int INTT_CNT      = 1
);
  localparam int S  = NTT_STAGE_CNT;
  localparam int DM = 1 << (S - 2);
  localparam int AW = $clog2(DM > MUL_STAGE_CNT ? DM : MUL_STAGE_CNT);
  localparam int MB = $clog2(MUL_STAGE_CNT - 1) > 1 ? $clog2(MUL_STAGE_CNT - 1) : 1;
  logic [NTT_CNT*S-1:0]  ntt_en;
  logic [INTT_CNT*S-1:0] intt_en;
  logic                  fifom_en;
  logic                  flush;
  logic                  clr_err;
  logic [MB-1:0]         fifom_addr;
  logic [S*AW-1:0]       fifo2_addr;
  logic [S*AW-1:0]       ntt_addr;
  logic [S*AW-1:0]       intt_addr;
  logic [S-1:0]          conflict;
  logic                  busy;
  modport master (
    output ntt_en, intt_en, fifom_en, flush, clr_err,
    input  fifom_addr, fifo2_addr, ntt_addr, intt_addr, conflict, busy
  );
  modport slave (
    input  ntt_en, intt_en, fifom_en, flush, clr_err,
    output fifom_addr, fifo2_addr, ntt_addr, intt_addr, conflict, busy
  );
endinterface

// File: rtl/fifo_addr_ctrl.sv
// fifo_addr_ctrl: per-stage wrap-around delay-FIFO pointers shared by NTT/INTT clients,
// with merged enables, sticky collision flags and synchronous flush.
module fifo_addr_ctrl #(
  parameter int NTT_STAGE_CNT = 8,
  parameter int MUL_STAGE_CNT = 4,
  parameter int NTT_CNT       = 1,
  parameter int INTT_CNT      = 1
) (
  input logic              clk,
  input logic              rst,
  fifo_addr_ctrl_if.slave  bus
);
  localparam int S  = NTT_STAGE_CNT;
  localparam int DM = 1 << (S - 2);
  localparam int AW = $clog2(DM > MUL_STAGE_CNT ? DM : MUL_STAGE_CNT);
  localparam int MB = $clog2(MUL_STAGE_CNT - 1) > 1 ? $clog2(MUL_STAGE_CNT - 1) : 1;
  localparam logic [MB-1:0] FM_LAST = MB'(MUL_STAGE_CNT - 2);

  function automatic logic [AW-1:0] last(input int k);
    return AW'((1 << (k < S - 2 ? k : S - 2)) - 1);
  endfunction

  logic [AW-1:0] p_q [S];
  logic [AW-1:0] p_d [S];
  logic [MB-1:0] fm_q, fm_d;
  logic [S-1:0]  cf_q, cf_d;
  logic [S-1:0]  en, col;
  logic [S*AW-1:0] p_flat;

  // NTT clients walk stages in reverse, so NTT stage S-1-k lands on controller stage k
  always_comb begin
    logic e, x;
    for (int k = 0; k < S; k++) begin
      e = 1'b0;
      x = 1'b0;
      for (int c = 0; c < NTT_CNT; c++) begin
        x = x | (e & bus.ntt_en[c*S+S-1-k]);
        e = e | bus.ntt_en[c*S+S-1-k];
      end
      for (int c = 0; c < INTT_CNT; c++) begin
        x = x | (e & bus.intt_en[c*S+k]);
        e = e | bus.intt_en[c*S+k];
      end
      en[k]  = e;
      col[k] = x;
    end
  end

  always_comb begin
    for (int k = 0; k < S; k++) begin
      p_d[k]  = bus.flush ? '0 : !en[k] ? p_q[k] : p_q[k] == last(k) ? '0 : p_q[k] + AW'(1);
      cf_d[k] = bus.flush ? 1'b0 : col[k] ? 1'b1 : bus.clr_err ? 1'b0 : cf_q[k];
    end
    fm_d = bus.flush ? '0 : !bus.fifom_en ? fm_q : fm_q == FM_LAST ? '0 : fm_q + MB'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) p_q[k] <= '0;
      fm_q <= '0;
      cf_q <= '0;
    end else begin
      for (int k = 0; k < S; k++) p_q[k] <= p_d[k];
      fm_q <= fm_d;
      cf_q <= cf_d;
    end
  end

  always_comb begin
    p_flat = '0;
    for (int k = 0; k < S; k++) p_flat[k*AW +: AW] = p_q[k];
  end

  for (genvar j = 0; j < S; j++) begin : g_map
    assign bus.ntt_addr[j*AW +: AW] = p_q[S-1-j];
  end

  assign bus.fifo2_addr = p_flat;
  assign bus.intt_addr  = p_flat;
  assign bus.fifom_addr = fm_q;
  assign bus.conflict   = cf_q;
  assign bus.busy       = |p_flat | |fm_q;
endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// tb_fifo_addr_ctrl: directed test-plan steps then random traffic, checked against
// an integer-arithmetic model of the stage pointers, fifom pointer and conflict flags.
module tb_fifo_addr_ctrl;
  localparam int S  = 8;
  localparam int MUL = 4;
  localparam int NC = 1;
  localparam int IC = 1;
  localparam int AW = 6;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_addr_ctrl_if #(.NTT_STAGE_CNT(S), .MUL_STAGE_CNT(MUL), .NTT_CNT(NC), .INTT_CNT(IC)) bus ();
  fifo_addr_ctrl #(.NTT_STAGE_CNT(S), .MUL_STAGE_CNT(MUL), .NTT_CNT(NC), .INTT_CNT(IC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int       ptr [S];
  int       fm;
  bit [S-1:0] cf;

  function automatic int depth(input int k);
    return 2 ** ((k < S - 2) ? k : S - 2);
  endfunction

  task automatic model(input logic [NC*S-1:0] ne, input logic [IC*S-1:0] ie,
                       input logic fe, input logic fl, input logic ce, input logic r);
    if (r || fl) begin
      foreach (ptr[k]) ptr[k] = 0;
      fm = 0;
      cf = '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        int n;
        n = 0;
        for (int c = 0; c < NC; c++) n += int'(ne[c*S + (S-1-k)]);
        for (int c = 0; c < IC; c++) n += int'(ie[c*S + k]);
        if (n > 0) ptr[k] = (ptr[k] + 1) % depth(k);
        if (n >= 2) cf[k] = 1'b1;
        else if (ce) cf[k] = 1'b0;
      end
      if (fe) fm = (fm + 1) % (MUL - 1);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [S*AW-1:0] e_ctl, e_ntt;
    bit busy_e;
    busy_e = (fm != 0);
    for (int k = 0; k < S; k++) begin
      e_ctl[k*AW +: AW] = AW'(ptr[k]);
      e_ntt[k*AW +: AW] = AW'(ptr[S-1-k]);
      if (ptr[k] != 0) busy_e = 1'b1;
    end
    chk("fifo2_addr", 64'(bus.fifo2_addr), 64'(e_ctl));
    chk("intt_addr",  64'(bus.intt_addr),  64'(e_ctl));
    chk("ntt_addr",   64'(bus.ntt_addr),   64'(e_ntt));
    chk("fifom_addr", 64'(bus.fifom_addr), 64'(fm));
    chk("conflict",   64'(bus.conflict),   64'(cf));
    chk("busy",       64'(bus.busy),       64'(busy_e));
  endtask

  task automatic step(input logic [NC*S-1:0] ne, input logic [IC*S-1:0] ie,
                      input logic fe, input logic fl, input logic ce, input logic r);
    bus.ntt_en   = ne;
    bus.intt_en  = ie;
    bus.fifom_en = fe;
    bus.flush    = fl;
    bus.clr_err  = ce;
    rst          = r;
    @(posedge clk);
    model(ne, ie, fe, fl, ce, r);
    #1;
    check_all();
  endtask

  function automatic logic [AW-1:0] istage(input int j);
    logic [S*AW-1:0] v;
    v = bus.intt_addr;
    return v[j*AW +: AW];
  endfunction

  initial begin
    logic [NC*S-1:0] ne;
    logic [IC*S-1:0] ie;
    foreach (ptr[k]) ptr[k] = 0;
    fm = 0;
    cf = '0;
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    // intt stage 3: 1..7,0,1 with busy low exactly at the 0
    for (int i = 1; i <= 9; i++) begin
      step('0, IC*S'(1 << 3), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("intt3_seq", 64'(istage(3)), 64'(i % 8));
      chk("intt3_busy", 64'(bus.busy), 64'(i % 8 != 0));
    end
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) step(NC*S'(1), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ntt0_wrap", 64'(istage(7)), 64'd0);
    chk("ntt0_noconf", 64'(bus.conflict[7]), 64'd0);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    // NTT stage 4 and INTT stage 3 both hit controller stage 3
    step(NC*S'(1 << 4), IC*S'(1 << 3), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("col_p3", 64'(istage(3)), 64'd1);
    chk("col_set", 64'(bus.conflict[3]), 64'd1);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("col_hold", 64'(bus.conflict[3]), 64'd1);
    step('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("col_clr", 64'(bus.conflict[3]), 64'd0);
    step(NC*S'(1 << 4), IC*S'(1 << 3), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("col_setwins", 64'(bus.conflict[3]), 64'd1);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fifom_seq", 64'(bus.fifom_addr), 64'(i % 3));
    end
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step('0, IC*S'(1 << 5), i < 2, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_p5", 64'(istage(5)), 64'd13);
    chk("pre_flush_fm", 64'(bus.fifom_addr), 64'd2);
    step('0, IC*S'(1 << 5), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush_addr", 64'(bus.fifo2_addr), 64'd0);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    step('0, IC*S'(1 << 5), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_p5", 64'(istage(5)), 64'd1);
    // enables under reset are ignored
    step(NC*S'(8'hFF), IC*S'(8'hFF), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_enables", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NC*S; b++) ne[b] = ($urandom_range(3) == 0);
      for (int b = 0; b < IC*S; b++) ie[b] = ($urandom_range(3) == 0);
      step(ne, ie, $urandom_range(1) == 1, $urandom_range(60) == 0,
           $urandom_range(7) == 0, $urandom_range(200) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
